// File: rtl/dcache_dm_wt.sv
// -----------------------------------------------------------------------------
// dcache_dm_wt
// Direct-mapped, write-through, no-write-allocate data cache with one-word
// lines. It sits between the CPU load/store stage and main memory.
//
// Only one request is outstanding at a time. Load hits complete on the cycle
// after acceptance. Load misses and all stores hold the memory enable for
// MEM_LATENCY cycles, then give a one-cycle response.
//
// Ports
//   clk, rst                : clock and synchronous active-high reset
//   cpu_req_valid/ready     : request handshake (accept on valid && ready)
//   cpu_req_write           : 1 = store, 0 = load
//   cpu_addr, cpu_wdata     : word address and store data
//   cpu_resp_valid          : one-cycle completion pulse
//   cpu_rdata               : load data, qualified by cpu_resp_valid
//                             (0 for stores)
//   mem_address             : address to main memory
//   mem_readEnable          : read enable to main memory
//   mem_writeEnable         : write enable to main memory
//   mem_dataIn              : write data to main memory
//   mem_dataOut             : read data from main memory
//   hit_count, miss_count   : saturating load hit/miss counters, present
//                             only when DCACHE_STATS_EN is defined
//
// Configuration macro: DCACHE_STATS_EN (optional statistics counters).
// -----------------------------------------------------------------------------
module dcache_dm_wt #(
    parameter int LINES       = 16,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_valid,
    input  logic              cpu_req_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_req_ready,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_readEnable,
    output logic              mem_writeEnable,
    output logic [DATA_W-1:0] mem_dataIn,
`ifdef DCACHE_STATS_EN
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
`endif
    input  logic [DATA_W-1:0] mem_dataOut
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;
    // The counter is at least one bit wide so that MEM_LATENCY=1 still works.
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESP   = 2'd1,
        ST_MEM_RD = 2'd2,
        ST_MEM_WR = 2'd3
    } state_t;

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [ADDR_W-1:0]   req_addr_r;
    logic                ready_r;
    logic                resp_valid_r;
    logic [DATA_W-1:0]   rdata_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic                mem_rd_r;
    logic                mem_wr_r;
    logic [DATA_W-1:0]   mem_din_r;

    // Line storage: valid bits are reset, tag and data are written on demand.
    logic [LINES-1:0]    valid_r;
    logic [TAG_W-1:0]    tag_r  [LINES];
    logic [DATA_W-1:0]   data_r [LINES];

    logic [IDX_W-1:0]    req_idx_s;
    logic [TAG_W-1:0]    req_tag_s;
    logic                hit_s;
    logic                accept_s;
    logic [IDX_W-1:0]    fill_idx_s;
    logic [TAG_W-1:0]    fill_tag_s;

    // Lookup of the incoming request and the acceptance condition.
    always_comb begin
        req_idx_s  = cpu_addr[IDX_W-1:0];
        req_tag_s  = cpu_addr[ADDR_W-1:IDX_W];
        fill_idx_s = req_addr_r[IDX_W-1:0];
        fill_tag_s = req_addr_r[ADDR_W-1:IDX_W];
        // ready_r is 1 only in IDLE, so acceptance needs no separate state test.
        accept_s   = cpu_req_valid & ready_r;
        if (valid_r[req_idx_s] && (tag_r[req_idx_s] == req_tag_s)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
    end

    // Control FSM. It also drives every registered output and updates the
    // line storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            req_addr_r   <= {ADDR_W{1'b0}};
            ready_r      <= 1'b0;
            resp_valid_r <= 1'b0;
            rdata_r      <= {DATA_W{1'b0}};
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_rd_r     <= 1'b0;
            mem_wr_r     <= 1'b0;
            mem_din_r    <= {DATA_W{1'b0}};
            valid_r      <= {LINES{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    resp_valid_r <= 1'b0;
                    mem_rd_r     <= 1'b0;
                    mem_wr_r     <= 1'b0;
                    mem_addr_r   <= {ADDR_W{1'b0}};
                    mem_din_r    <= {DATA_W{1'b0}};
                    cnt_r        <= {CNT_W{1'b0}};
                    if (accept_s) begin
                        ready_r    <= 1'b0;
                        req_addr_r <= cpu_addr;
                        if (cpu_req_write) begin
                            // Write-through: memory always sees the store.
                            // A resident line is refreshed so later loads hit.
                            state_r    <= ST_MEM_WR;
                            mem_wr_r   <= 1'b1;
                            mem_addr_r <= cpu_addr;
                            mem_din_r  <= cpu_wdata;
                            if (hit_s) begin
                                data_r[req_idx_s] <= cpu_wdata;
                            end else begin
                                data_r[req_idx_s] <= data_r[req_idx_s];
                            end
                        end else if (hit_s) begin
                            state_r      <= ST_RESP;
                            resp_valid_r <= 1'b1;
                            rdata_r      <= data_r[req_idx_s];
                        end else begin
                            state_r    <= ST_MEM_RD;
                            mem_rd_r   <= 1'b1;
                            mem_addr_r <= cpu_addr;
                        end
                    end else begin
                        ready_r <= 1'b1;
                    end
                end

                ST_MEM_RD: begin
                    if (cnt_r == CNT_LAST) begin
                        // Last enabled cycle: capture the memory word into the
                        // line and into the response.
                        state_r              <= ST_RESP;
                        cnt_r                <= {CNT_W{1'b0}};
                        mem_rd_r             <= 1'b0;
                        mem_addr_r           <= {ADDR_W{1'b0}};
                        resp_valid_r         <= 1'b1;
                        rdata_r              <= mem_dataOut;
                        valid_r[fill_idx_s]  <= 1'b1;
                        tag_r[fill_idx_s]    <= fill_tag_s;
                        data_r[fill_idx_s]   <= mem_dataOut;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end

                ST_MEM_WR: begin
                    if (cnt_r == CNT_LAST) begin
                        state_r      <= ST_RESP;
                        cnt_r        <= {CNT_W{1'b0}};
                        mem_wr_r     <= 1'b0;
                        mem_addr_r   <= {ADDR_W{1'b0}};
                        mem_din_r    <= {DATA_W{1'b0}};
                        resp_valid_r <= 1'b1;
                        rdata_r      <= {DATA_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end

                ST_RESP: begin
                    state_r      <= ST_IDLE;
                    resp_valid_r <= 1'b0;
                    rdata_r      <= {DATA_W{1'b0}};
                    ready_r      <= 1'b1;
                end

                default: begin
                    // Unreachable encoding: return to a quiet IDLE.
                    state_r      <= ST_IDLE;
                    cnt_r        <= {CNT_W{1'b0}};
                    ready_r      <= 1'b0;
                    resp_valid_r <= 1'b0;
                    rdata_r      <= {DATA_W{1'b0}};
                    mem_rd_r     <= 1'b0;
                    mem_wr_r     <= 1'b0;
                    mem_addr_r   <= {ADDR_W{1'b0}};
                    mem_din_r    <= {DATA_W{1'b0}};
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_r;
    logic [31:0] miss_count_r;

    // Saturating load hit/miss counters, stepped at request acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_r  <= 32'd0;
            miss_count_r <= 32'd0;
        end else if (accept_s && !cpu_req_write) begin
            if (hit_s) begin
                if (hit_count_r != 32'hFFFF_FFFF) begin
                    hit_count_r <= hit_count_r + 32'd1;
                end else begin
                    hit_count_r <= hit_count_r;
                end
            end else begin
                if (miss_count_r != 32'hFFFF_FFFF) begin
                    miss_count_r <= miss_count_r + 32'd1;
                end else begin
                    miss_count_r <= miss_count_r;
                end
            end
        end else begin
            hit_count_r  <= hit_count_r;
            miss_count_r <= miss_count_r;
        end
    end

    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;
`endif

    assign cpu_req_ready   = ready_r;
    assign cpu_resp_valid  = resp_valid_r;
    assign cpu_rdata       = rdata_r;
    assign mem_address     = mem_addr_r;
    assign mem_readEnable  = mem_rd_r;
    assign mem_writeEnable = mem_wr_r;
    assign mem_dataIn      = mem_din_r;

endmodule
